opsg_wr_arbiter: RTL and testbench

Shares the single byte-wide PSG write port (psg_n_wr / psg_data) between two bus requesters, e.g. 68k-side and Z80-side register writes.
- Paces strobes with a guaranteed idle gap between writes.
- Arbitrates round-robin between the two requesters.
- Keeps a tone latch byte and its following data byte atomic, so the other requester cannot corrupt the PSG's "previous register" tracking.
- Sits between the bus interface logic and the opsg core.

---
 rtl/opsg_pkg.sv | 19 +
 rtl/opsg_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_opsg_wr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opsg_pkg.sv
// rtl/opsg_pkg.sv - shared state encoding, PSG byte field constants and tone-latch classifier
package opsg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } arb_state_t;

  localparam int         LATCH_BIT = 7;
  localparam int         TYPE_BIT  = 4;
  localparam logic [1:0] NOISE_CH  = 2'b11;

  // Tone latches carry the low frequency nibble and are followed by a data byte.
  function automatic logic is_tone_latch(input logic [7:0] b);
    return b[LATCH_BIT] && !b[TYPE_BIT] && (b[6:5] != NOISE_CH);
  endfunction

endpackage

// File: rtl/opsg_wr_arbiter.sv
// rtl/opsg_wr_arbiter.sv - paced round-robin arbiter for the shared PSG write port
// Keeps a tone latch and its following data byte from the same requester back to back.
module opsg_wr_arbiter
  import opsg_pkg::*;
#(
  parameter int WR_GAP       = 2,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       psg_n_wr,
  output logic [7:0] psg_data,
  output logic       busy,
  output logic       locked
);

  localparam int GAP_SPAN = (WR_GAP > 2) ? WR_GAP : 2;
  localparam int TMO_SPAN = (LOCK_TIMEOUT > 2) ? LOCK_TIMEOUT : 2;
  localparam int GAP_W    = $clog2(GAP_SPAN) + 1;
  localparam int TMO_W    = $clog2(TMO_SPAN) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(LOCK_TIMEOUT);

  arb_state_t       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             locked_d, n_wr_d, ack0_d, ack1_d;
  logic [7:0]       data_d;

  logic             counting, expire, eff_locked;
  logic             cand0, cand1, pick1;
  logic [7:0]       pick_byte;

  // The timeout only runs while the port is quiet; the strobe cycle itself is not counted.
  assign counting   = locked && (state_q != STROBE);
  assign tmo_inc    = (tmo_q == TMO_LIMIT) ? tmo_q : tmo_q + TMO_W'(1);
  assign expire     = counting && (tmo_inc == TMO_LIMIT);
  assign eff_locked = locked && !expire;

  assign cand0     = req0 && (!eff_locked || !owner_q);
  assign cand1     = req1 && (!eff_locked || owner_q);
  assign pick1     = cand1 && (!cand0 || !last_q);
  assign pick_byte = pick1 ? data1 : data0;

  assign busy = (state_q != IDLE) || locked;

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    owner_d  = owner_q;
    last_d   = last_q;
    locked_d = locked;
    n_wr_d   = 1'b1;
    data_d   = psg_data;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    if (counting) begin
      tmo_d = tmo_inc;
    end
    if (expire) begin
      locked_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cand0 || cand1) begin
          n_wr_d   = 1'b0;
          data_d   = pick_byte;
          ack0_d   = !pick1;
          ack1_d   = pick1;
          last_d   = pick1;
          owner_d  = pick1;
          // Any owner byte other than a fresh tone latch ends the atomic pair.
          locked_d = is_tone_latch(pick_byte);
          tmo_d    = '0;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        gap_d   = '0;
        state_d = (WR_GAP == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      tmo_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      locked   <= 1'b0;
      psg_n_wr <= 1'b1;
      psg_data <= 8'h00;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      locked   <= locked_d;
      psg_n_wr <= n_wr_d;
      psg_data <= data_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
    end
  end

endmodule

// File: tb/tb_opsg_wr_arbiter.sv
// tb/tb_opsg_wr_arbiter.sv - vector table, directed lock/reset sequences and random traffic vs a reference model
module tb_opsg_wr_arbiter;

  localparam int WR_GAP       = 2;
  localparam int LOCK_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, psg_n_wr, busy, locked;
  logic [7:0] psg_data;

  opsg_wr_arbiter #(.WR_GAP(WR_GAP), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .req0     (req0),
    .data0    (data0),
    .ack0     (ack0),
    .req1     (req1),
    .data1    (data1),
    .ack1     (ack1),
    .psg_n_wr (psg_n_wr),
    .psg_data (psg_data),
    .busy     (busy),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    logic       r0;
    logic [7:0] d0;
    logic       r1;
    logic [7:0] d1;
    logic       nwr;
    logic [7:0] dat;
    logic       a0;
    logic       a1;
    logic       bsy;
    logic       lck;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(logic r0, logic [7:0] d0, logic r1, logic [7:0] d1,
                              logic nwr, logic [7:0] dat, logic a0, logic a1,
                              logic bsy, logic lck);
    vec_t v;
    v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1;
    v.nwr = nwr; v.dat = dat; v.a0 = a0; v.a1 = a1; v.bsy = bsy; v.lck = lck;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_strobe(input int limit, output logic [7:0] d, output int n);
    n = 0;
    d = 8'h00;
    do begin
      step();
      n++;
    end while (psg_n_wr && n <= limit);
    if (!psg_n_wr) d = psg_data;
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    case ($urandom_range(0, 2))
      0:       b = {1'b1, 2'($urandom_range(0, 2)), 1'b0, 4'($urandom)};
      1:       b = {1'b0, 7'($urandom)};
      default: b = 8'($urandom);
    endcase
    return b;
  endfunction

  function automatic bit ref_tone(logic [7:0] b);
    return ((b & 8'h90) == 8'h80) && ((b & 8'h60) != 8'h60);
  endfunction

  task automatic run_random(input int cycles);
    int         last_strobe = -1000;
    int         lock_s      = 0;
    bit         lock_valid  = 0;
    int         lock_own    = 0;
    int         last_g      = 1;
    bit         pend        = 0;
    int         pend_who    = 0;
    logic [7:0] pend_data   = 8'h00;
    int         hold0 = 0, hold1 = 0;
    bit         e_nwr, e0, e1, e_lock, e_busy, eff, c0, c1;
    for (int i = 0; i < cycles; i++) begin
      step();
      e_nwr = 1; e0 = 0; e1 = 0;
      if (pend) begin
        e_nwr = 0;
        e0 = (pend_who == 0);
        e1 = (pend_who == 1);
        last_strobe = cyc;
        lock_valid = ref_tone(pend_data);
        lock_s = cyc;
        lock_own = pend_who;
        last_g = pend_who;
        pend = 0;
      end
      e_lock = lock_valid && (cyc <= lock_s + LOCK_TIMEOUT);
      e_busy = ((cyc - last_strobe) <= WR_GAP) || e_lock;
      chk("rnd psg_n_wr", psg_n_wr, e_nwr);
      chk("rnd ack0", ack0, e0);
      chk("rnd ack1", ack1, e1);
      chk("rnd locked", locked, e_lock);
      chk("rnd busy", busy, e_busy);
      if (!e_nwr) chk("rnd psg_data", psg_data, pend_data);

      if (e0) begin
        if ($urandom_range(0, 1) == 1) data0 = rnd_byte();
        else begin req0 = 0; hold0 = $urandom_range(0, 90); end
      end else if (!req0) begin
        if (hold0 > 0) hold0--;
        else if ($urandom_range(0, 3) == 0) begin req0 = 1; data0 = rnd_byte(); end
      end
      if (e1) begin
        if ($urandom_range(0, 1) == 1) data1 = rnd_byte();
        else begin req1 = 0; hold1 = $urandom_range(0, 90); end
      end else if (!req1) begin
        if (hold1 > 0) hold1--;
        else if ($urandom_range(0, 3) == 0) begin req1 = 1; data1 = rnd_byte(); end
      end

      if (cyc > last_strobe + WR_GAP) begin
        eff = lock_valid && (cyc < lock_s + LOCK_TIMEOUT);
        c0 = req0 && (!eff || lock_own == 0);
        c1 = req1 && (!eff || lock_own == 1);
        if (c0 || c1) begin
          pend = 1;
          pend_who = (c0 && c1) ? 1 - last_g : (c1 ? 1 : 0);
          pend_data = pend_who ? data1 : data0;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n, strobes, unl, acks;

    vecs[0]  = mk(1, 8'h9F, 1, 8'hDF, 0, 8'h9F, 1, 0, 1, 0);
    vecs[1]  = mk(1, 8'h9F, 1, 8'hDF, 1, 8'h00, 0, 0, 1, 0);
    vecs[2]  = mk(1, 8'h9F, 1, 8'hDF, 1, 8'h00, 0, 0, 1, 0);
    vecs[3]  = mk(1, 8'h9F, 1, 8'hDF, 1, 8'h00, 0, 0, 0, 0);
    vecs[4]  = mk(1, 8'h9F, 1, 8'hDF, 0, 8'hDF, 0, 1, 1, 0);
    vecs[5]  = mk(1, 8'h9F, 1, 8'hDF, 1, 8'h00, 0, 0, 1, 0);
    vecs[6]  = mk(1, 8'h9F, 1, 8'hDF, 1, 8'h00, 0, 0, 1, 0);
    vecs[7]  = mk(1, 8'h9F, 1, 8'hDF, 1, 8'h00, 0, 0, 0, 0);
    vecs[8]  = mk(1, 8'h9F, 1, 8'hDF, 0, 8'h9F, 1, 0, 1, 0);
    vecs[9]  = mk(1, 8'h9F, 1, 8'hDF, 1, 8'h00, 0, 0, 1, 0);
    vecs[10] = mk(1, 8'h9F, 1, 8'hDF, 1, 8'h00, 0, 0, 1, 0);
    vecs[11] = mk(1, 8'h9F, 1, 8'hDF, 1, 8'h00, 0, 0, 0, 0);
    vecs[12] = mk(1, 8'h9F, 1, 8'hDF, 0, 8'hDF, 0, 1, 1, 0);
    vecs[13] = mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0);
    vecs[14] = mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0);
    vecs[15] = mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    vecs[16] = mk(1, 8'h9F, 0, 8'h00, 0, 8'h9F, 1, 0, 1, 0);
    vecs[17] = mk(1, 8'hBF, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0);
    vecs[18] = mk(1, 8'hBF, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0);
    vecs[19] = mk(1, 8'hBF, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    vecs[20] = mk(1, 8'hBF, 0, 8'h00, 0, 8'hBF, 1, 0, 1, 0);
    vecs[21] = mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0);
    vecs[22] = mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0);
    vecs[23] = mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    vecs[24] = mk(1, 8'hE4, 0, 8'h00, 0, 8'hE4, 1, 0, 1, 0);
    vecs[25] = mk(0, 8'h00, 1, 8'h9F, 1, 8'h00, 0, 0, 1, 0);
    vecs[26] = mk(0, 8'h00, 1, 8'h9F, 1, 8'h00, 0, 0, 1, 0);
    vecs[27] = mk(0, 8'h00, 1, 8'h9F, 1, 8'h00, 0, 0, 0, 0);
    vecs[28] = mk(0, 8'h00, 1, 8'h9F, 0, 8'h9F, 0, 1, 1, 0);
    vecs[29] = mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0);
    vecs[30] = mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 1, 0);
    vecs[31] = mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);

    n_rst = 1'b0;
    req0 = 0; req1 = 0; data0 = 8'h00; data1 = 8'h00;
    repeat (3) step();
    chk("reset psg_n_wr", psg_n_wr, 1);
    chk("reset psg_data", psg_data, 8'h00);
    chk("reset ack0", ack0, 0);
    chk("reset ack1", ack1, 0);
    chk("reset busy", busy, 0);
    chk("reset locked", locked, 0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      req0 = vecs[i].r0; data0 = vecs[i].d0;
      req1 = vecs[i].r1; data1 = vecs[i].d1;
      step();
      chk($sformatf("vec%0d psg_n_wr", i), psg_n_wr, vecs[i].nwr);
      chk($sformatf("vec%0d ack0", i), ack0, vecs[i].a0);
      chk($sformatf("vec%0d ack1", i), ack1, vecs[i].a1);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
      chk($sformatf("vec%0d locked", i), locked, vecs[i].lck);
      if (!vecs[i].nwr) chk($sformatf("vec%0d psg_data", i), psg_data, vecs[i].dat);
    end

    // Tone latch 0x85 keeps req0's data byte 0x12 ahead of req1's pending 0xBF.
    req0 = 1; data0 = 8'h85;
    step();
    chk("t4 strobe 85 n_wr", psg_n_wr, 0);
    chk("t4 strobe 85 data", psg_data, 8'h85);
    chk("t4 locked after 85", locked, 1);
    req0 = 0; req1 = 1; data1 = 8'hBF;
    step();
    chk("t4 locked gap1", locked, 1);
    req0 = 1; data0 = 8'h12;
    step();
    chk("t4 locked gap2", locked, 1);
    step();
    chk("t4 locked idle", locked, 1);
    chk("t4 no strobe idle", psg_n_wr, 1);
    step();
    chk("t4 strobe 12 n_wr", psg_n_wr, 0);
    chk("t4 strobe 12 data", psg_data, 8'h12);
    chk("t4 strobe 12 ack0", ack0, 1);
    chk("t4 unlocked at 12", locked, 0);
    req0 = 0;
    wait_strobe(10, d, n);
    chk("t4 third strobe data", d, 8'hBF);
    chk("t4 third strobe spacing", n, WR_GAP + 2);
    chk("t4 third strobe ack1", ack1, 1);
    req1 = 0;

    // Abandoned lock: 0xBF from req1 waits out the full timeout.
    req0 = 1; data0 = 8'h85;
    wait_strobe(10, d, n);
    chk("t5 strobe 85", d, 8'h85);
    req0 = 0; req1 = 1; data1 = 8'hBF;
    strobes = 0; unl = 0;
    for (int k = 1; k <= LOCK_TIMEOUT; k++) begin
      step();
      if (!psg_n_wr) strobes++;
      if (!locked) unl++;
    end
    chk("t5 strobes while locked", strobes, 0);
    chk("t5 lock dropped early", unl, 0);
    step();
    chk("t5 locked after timeout", locked, 0);
    chk("t5 BF strobe n_wr", psg_n_wr, 0);
    chk("t5 BF strobe data", psg_data, 8'hBF);
    chk("t5 BF strobe ack1", ack1, 1);
    req1 = 0;

    // Asynchronous reset in the gap after a tone latch.
    req0 = 1; data0 = 8'h85;
    wait_strobe(10, d, n);
    chk("rst pre strobe 85", d, 8'h85);
    req0 = 0;
    step();
    chk("rst pre locked", locked, 1);
    chk("rst pre busy", busy, 1);
    #3;
    n_rst = 1'b0;
    #1;
    chk("rst async psg_n_wr", psg_n_wr, 1);
    chk("rst async psg_data", psg_data, 8'h00);
    chk("rst async ack0", ack0, 0);
    chk("rst async ack1", ack1, 0);
    chk("rst async busy", busy, 0);
    chk("rst async locked", locked, 0);
    @(negedge clk);
    n_rst = 1'b1;
    acks = 0; strobes = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ack0 || ack1) acks++;
      if (!psg_n_wr) strobes++;
    end
    chk("rst no ack after release", acks, 0);
    chk("rst no strobe after release", strobes, 0);

    run_random(1500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
